// File: rtl/systolic_pkg.sv
// Shared types and array geometry for the systolic-array job sequencer.
// Holds the sequencer state encoding and the operand/result layout constants.
package systolic_pkg;

    localparam int ARR_DIM     = 4;
    localparam int SKEW        = ARR_DIM - 1;
    localparam int COLS        = 256;
    localparam int RES_PER_JOB = ARR_DIM * ARR_DIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/seq_counter.sv
// Loadable down-counter with a terminal-count flag; stops at zero.
// Load takes priority over counting.
module seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer for the 4x4 output-stationary systolic array: fetch K, stream skewed
// operand columns, flush, drain 16 accumulators. Optional cycle counter: SEQ_PERF_EN.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int FLUSH_CYC = 6,
    parameter int N_INSTR   = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              busy,
    output logic              err,
    output logic [2:0]        instr_addr,
    input  logic [3:0]        instr_data,
    output logic              mem_rd_en,
    output logic [7:0]        col_addr,
    output logic              arr_valid,
    output logic              arr_clear,
    output logic [3:0]        drain_sel,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_we,
    output logic [6:0]        out_addr,
    output logic [DATA_W-1:0] out_data,
`ifdef SEQ_PERF_EN
    output logic [15:0]       perf_cycles,
`endif
    output logic [3:0]        curr_instr
);

    seq_state_e state_q, state_n;

    logic [2:0]  idx_q;
    logic [8:0]  base_q;
    logic        start_acc;
    logic        ovf;
    logic [9:0]  end_col;

    logic        stream_load, flush_load, drain_load;
    logic [4:0]  stream_cnt;
    logic        stream_tc;
    logic [15:0] unused_flush_cnt;
    logic        flush_tc;
    logic [3:0]  drain_cnt;
    logic        drain_tc;

    logic [7:0]  col_next;
    logic [3:0]  sel_next;

    assign start_acc = (state_q == S_IDLE) && ap_start;
    assign end_col   = {1'b0, base_q} + 10'(instr_data) + 10'(SKEW);
    assign ovf       = (end_col > 10'(COLS));

    // Next column/select are derived from the remaining count of the running phase.
    assign col_next  = base_q[7:0] + 8'(curr_instr) + 8'(SKEW) - 8'(stream_cnt);
    assign sel_next  = 4'(RES_PER_JOB - 1) - drain_cnt + 4'd1;

    assign instr_addr = idx_q;
    assign out_addr   = {idx_q, drain_sel};
    assign out_data   = res_data;

    seq_counter #(.W(5)) u_stream_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (stream_load),
        .load_val (5'(curr_instr) + 5'(SKEW - 1)),
        .en       (state_q == S_STREAM),
        .count    (stream_cnt),
        .tc       (stream_tc)
    );

    seq_counter #(.W(16)) u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (flush_load),
        .load_val (16'(FLUSH_CYC - 1)),
        .en       (state_q == S_FLUSH),
        .count    (unused_flush_cnt),
        .tc       (flush_tc)
    );

    seq_counter #(.W(4)) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (4'(RES_PER_JOB - 1)),
        .en       (state_q == S_DRAIN),
        .count    (drain_cnt),
        .tc       (drain_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        stream_load = 1'b0;
        flush_load  = 1'b0;
        drain_load  = 1'b0;
        case (state_q)
            S_IDLE:   if (ap_start) state_n = S_FETCH;
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                if (instr_data == 4'd0 || ovf) state_n = S_DONE;
                else                           state_n = S_CLEAR;
            end
            S_CLEAR: begin
                state_n     = S_STREAM;
                stream_load = 1'b1;
            end
            S_STREAM: begin
                if (stream_tc) begin
                    state_n    = S_FLUSH;
                    flush_load = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_tc) begin
                    state_n    = S_DRAIN;
                    drain_load = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_tc) begin
                    if (idx_q == 3'(N_INSTR - 1)) state_n = S_DONE;
                    else                          state_n = S_FETCH;
                end
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are loaded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            base_q     <= '0;
            err        <= 1'b0;
            curr_instr <= '0;
            busy       <= 1'b0;
            ap_done    <= 1'b0;
            arr_clear  <= 1'b0;
            mem_rd_en  <= 1'b0;
            arr_valid  <= 1'b0;
            out_we     <= 1'b0;
            col_addr   <= '0;
            drain_sel  <= '0;
        end else begin
            busy      <= (state_n != S_IDLE);
            ap_done   <= (state_n == S_DONE);
            arr_clear <= (state_n == S_CLEAR);
            mem_rd_en <= (state_n == S_STREAM);
            arr_valid <= mem_rd_en;
            out_we    <= (state_n == S_DRAIN);

            if (state_n == S_STREAM) begin
                col_addr <= (state_q == S_STREAM) ? col_next : base_q[7:0];
            end
            if (state_n == S_DRAIN) begin
                drain_sel <= (state_q == S_DRAIN) ? sel_next : 4'd0;
            end

            if (start_acc) begin
                idx_q  <= '0;
                base_q <= '0;
                err    <= 1'b0;
            end

            if (state_q == S_DECODE && instr_data != 4'd0) begin
                if (ovf) err        <= 1'b1;
                else     curr_instr <= instr_data;
            end

            if (state_q == S_DRAIN && drain_tc) begin
                base_q <= base_q + 9'(curr_instr) + 9'(SKEW);
                idx_q  <= idx_q + 3'd1;
            end

            if (state_n == S_DONE) begin
                curr_instr <= '0;
            end
        end
    end

`ifdef SEQ_PERF_EN
    // Counts FETCH through DRAIN; DONE and IDLE leave the value frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (state_q != S_IDLE && state_q != S_DONE && perf_cycles != 16'hFFFF) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: a job-level model queues expected reads,
// clears, writes and done pulses; a negedge monitor pops and compares them.
module tb_systolic_sequencer;

    localparam int FLUSH = 6;
    localparam int NI    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ap_start;
    logic        ap_done, busy, err;
    logic [2:0]  instr_addr;
    logic [3:0]  instr_data;
    logic        mem_rd_en;
    logic [7:0]  col_addr;
    logic        arr_valid, arr_clear;
    logic [3:0]  drain_sel;
    logic [31:0] res_data;
    logic        out_we;
    logic [6:0]  out_addr;
    logic [31:0] out_data;
    logic [3:0]  curr_instr;
`ifdef SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    systolic_sequencer #(.FLUSH_CYC(FLUSH), .N_INSTR(NI), .DATA_W(32)) dut (
        .clk        (clk),
`ifdef SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .rst        (rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .busy       (busy),
        .err        (err),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .mem_rd_en  (mem_rd_en),
        .col_addr   (col_addr),
        .arr_valid  (arr_valid),
        .arr_clear  (arr_clear),
        .drain_sel  (drain_sel),
        .res_data   (res_data),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .curr_instr (curr_instr)
    );

    always #5 clk = ~clk;

    logic [3:0]  prog_mem [NI];
    logic [31:0] res_tab  [16];
    int          prog     [NI];

    always @(posedge clk) instr_data <= prog_mem[instr_addr];
    assign res_data = res_tab[drain_sel];

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        int          rel;
        logic [31:0] val;
        int          aux;
    } ev_t;

    ev_t rd_q[$], va_q[$], clr_q[$], wr_q[$], done_q[$];

    int  tests = 0;
    int  failed = 0;
    int  t0 = 0;
    bit  running = 0;
    bit  done_seen = 0;
    int  last_done_rel = -1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Job-level model: walks the program and lists every observable event by cycle.
    task automatic build_model(input int base0);
        int cyc, base, k, d, done_rel, e;
        cyc = 1; base = base0; e = 0; done_rel = -1;
        for (int j = 0; j < NI; j++) begin
            k = prog[j];
            if (k == 0) begin
                done_rel = cyc + 2;
                break;
            end
            if (base + k + 3 > 256) begin
                e = 1;
                done_rel = cyc + 2;
                break;
            end
            clr_q.push_back('{cyc + 2, 32'd0, 0});
            for (int t = 0; t < k + 3; t++) begin
                rd_q.push_back('{cyc + 3 + t, 32'((base + t) % 256), k});
                va_q.push_back('{cyc + 4 + t, 32'd0, 0});
            end
            d = cyc + 3 + (k + 3) + FLUSH;
            for (int s = 0; s < 16; s++) begin
                wr_q.push_back('{d + s, res_tab[s], j * 16 + s});
            end
            cyc = d + 16;
            base = base + k + 3;
            if (j == NI - 1) done_rel = cyc;
        end
        done_q.push_back('{done_rel, 32'(e), 0});
    endtask

    int  mrel;
    ev_t me;
    always @(negedge clk) begin
        if (running) begin
            mrel = cycle_cnt - t0;
            if (mem_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 64'(mem_rd_en), 64'd0);
                else begin
                    me = rd_q.pop_front();
                    chk("rd_cycle", 64'(mrel), 64'(me.rel));
                    chk("rd_col", 64'(col_addr), 64'(me.val));
                    chk("rd_curr_instr", 64'(curr_instr), 64'(me.aux));
                end
            end
            if (arr_valid) begin
                if (va_q.size() == 0) chk("valid_unexpected", 64'(arr_valid), 64'd0);
                else begin
                    me = va_q.pop_front();
                    chk("valid_cycle", 64'(mrel), 64'(me.rel));
                end
            end
            if (arr_clear) begin
                if (clr_q.size() == 0) chk("clear_unexpected", 64'(arr_clear), 64'd0);
                else begin
                    me = clr_q.pop_front();
                    chk("clear_cycle", 64'(mrel), 64'(me.rel));
                end
            end
            if (out_we) begin
                if (wr_q.size() == 0) chk("we_unexpected", 64'(out_we), 64'd0);
                else begin
                    me = wr_q.pop_front();
                    chk("wr_cycle", 64'(mrel), 64'(me.rel));
                    chk("wr_addr", 64'(out_addr), 64'(me.aux));
                    chk("wr_data", 64'(out_data), 64'(me.val));
                end
            end
            if (ap_done) begin
                if (done_q.size() == 0) chk("done_unexpected", 64'(ap_done), 64'd0);
                else begin
                    me = done_q.pop_front();
                    chk("done_cycle", 64'(mrel), 64'(me.rel));
                    chk("done_err", 64'(err), 64'(me.val));
                    chk("done_curr_instr", 64'(curr_instr), 64'd0);
                end
                done_seen = 1;
                last_done_rel = mrel;
            end
        end
    end

    task automatic clear_queues();
        rd_q.delete(); va_q.delete(); clr_q.delete(); wr_q.delete(); done_q.delete();
    endtask

    task automatic start_run(input int base0, input bit hold);
        for (int i = 0; i < NI; i++) prog_mem[i] = 4'(prog[i]);
        for (int s = 0; s < 16; s++) res_tab[s] = $urandom();
        clear_queues();
        build_model(base0);
        done_seen = 0;
        last_done_rel = -1;
        @(posedge clk); #2;
        ap_start = 1'b1;
        @(posedge clk); #2;
        t0 = cycle_cnt - 1;
        running = 1;
        if (!hold) ap_start = 1'b0;
    endtask

    task automatic finish_run();
        for (int i = 0; i < 2000 && !done_seen; i++) @(posedge clk);
        #2;
        ap_start = 1'b0;
        if (!done_seen) begin
            tests++;
            failed++;
            $display("FAIL done_timeout: got no ap_done expected one within 2000 cycles");
        end
        repeat (4) @(posedge clk);
        #2;
        chk("busy_after_run", 64'(busy), 64'd0);
        chk("events_outstanding", 64'(rd_q.size() + va_q.size() + clr_q.size() + wr_q.size() + done_q.size()), 64'd0);
        running = 0;
        clear_queues();
    endtask

    task automatic check_quiet_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ap_done"}, 64'(ap_done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_arr_valid"}, 64'(arr_valid), 64'd0);
        chk({tag, "_arr_clear"}, 64'(arr_clear), 64'd0);
        chk({tag, "_out_we"}, 64'(out_we), 64'd0);
        chk({tag, "_col_addr"}, 64'(col_addr), 64'd0);
        chk({tag, "_drain_sel"}, 64'(drain_sel), 64'd0);
        chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_instr_addr"}, 64'(instr_addr), 64'd0);
        chk({tag, "_curr_instr"}, 64'(curr_instr), 64'd0);
    endtask

    task automatic set_prog(input int a0, a1, a2, a3, a4, a5, a6, a7);
        prog[0] = a0; prog[1] = a1; prog[2] = a2; prog[3] = a3;
        prog[4] = a4; prog[5] = a5; prog[6] = a6; prog[7] = a7;
    endtask

    int act_cnt;
    int nj;

    initial begin
        rst = 1'b1;
        ap_start = 1'b0;
        for (int i = 0; i < NI; i++) prog_mem[i] = 4'd0;
        for (int s = 0; s < 16; s++) res_tab[s] = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check_quiet_outputs("reset");
        rst = 1'b0;

        // Mixed-K program from the reference plan
        set_prog(5, 4, 1, 2, 3, 0, 0, 0);
        start_run(0, 1'b0);
        finish_run();
        chk("prog1_done_cycle", 64'(last_done_rel), 64'd158);

        // Single long job
        set_prog(15, 0, 0, 0, 0, 0, 0, 0);
        start_run(0, 1'b0);
        finish_run();

        // Full program: ends after job 7 with no terminating fetch
        set_prog(15, 15, 15, 15, 15, 15, 15, 15);
        start_run(0, 1'b0);
        finish_run();

        // Column overflow with the base preset high
        set_prog(4, 0, 0, 0, 0, 0, 0, 0);
        force dut.base_q = 9'd250;
        start_run(250, 1'b0);
        finish_run();
        release dut.base_q;
        chk("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of STREAM, then rerun the same program
        set_prog(5, 4, 1, 2, 3, 0, 0, 0);
        start_run(0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        running = 0;
        check_quiet_outputs("abort");
        clear_queues();
        act_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_we || ap_done || mem_rd_en || arr_valid || arr_clear || busy) act_cnt++;
        end
        chk("quiet_after_rst", 64'(act_cnt), 64'd0);
        start_run(0, 1'b0);
        finish_run();
        chk("rerun_done_cycle", 64'(last_done_rel), 64'd158);

        // ap_start held high for the whole run
        set_prog(3, 7, 0, 0, 0, 0, 0, 0);
        start_run(0, 1'b1);
        finish_run();

        // Randomized programs
        for (int r = 0; r < 5; r++) begin
            nj = $urandom_range(0, NI);
            for (int i = 0; i < NI; i++) prog[i] = (i < nj) ? int'($urandom_range(1, 15)) : 0;
            start_run(0, (r % 2) == 1);
            finish_run();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
